// File: rtl/multicycle_cu.sv
// multicycle_cu: multi-cycle control unit and datapath.
// An FSM steps FETCH -> DECODE -> EXEC -> (MEM) -> (WB) against an external
// instruction memory and data memory. Both memories use a req/ack handshake,
// so wait-state memories are supported.
// Optional feature macro: CU_HALT_EN (op 0x3F enters a HALT state, exit only by reset).
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   imem_req/addr   fetch request (held until imem_ack) and word address (= pc)
//   imem_rdata/ack  instruction word and fetch-complete strobe
//   dmem_req/we     data request (held until dmem_ack), 1=store 0=load
//   dmem_addr/wdata data word address and store data, stable while dmem_req=1
//   dmem_rdata/ack  load data and access-complete strobe
//   pc              current program counter
//   retire          one-cycle pulse per completed instruction
//   halted          core stopped (always 0 unless CU_HALT_EN)
module multicycle_cu #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NREGS       = 32,
   parameter int unsigned PC_WIDTH    = 10,
   parameter int unsigned DADDR_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [31:0]            imem_rdata,
   input  logic                   imem_ack,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [DADDR_WIDTH-1:0] dmem_addr,
   output logic [XLEN-1:0]        dmem_wdata,
   input  logic [XLEN-1:0]        dmem_rdata,
   input  logic                   dmem_ack,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   retire,
   output logic                   halted
);

   localparam int unsigned RF_DEPTH = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h01;
   localparam logic [5:0] OP_BNE   = 6'h02;
   localparam logic [5:0] OP_J     = 6'h07;
   localparam logic [5:0] OP_JR    = 6'h08;
   localparam logic [5:0] OP_JAL   = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0B;
   localparam logic [5:0] OP_LW    = 6'h0C;
   localparam logic [5:0] OP_SW    = 6'h0D;
   localparam logic [5:0] OP_ADDI  = 6'h0F;
   localparam logic [5:0] OP_ANDI  = 6'h14;
   localparam logic [5:0] OP_ORI   = 6'h15;
`ifdef CU_HALT_EN
   localparam logic [5:0] OP_HALT  = 6'h3F;
`endif

   localparam logic [5:0] FN_SUB = 6'd1;
   localparam logic [5:0] FN_AND = 6'd2;
   localparam logic [5:0] FN_OR  = 6'd3;
   localparam logic [5:0] FN_SLL = 6'd4;
   localparam logic [5:0] FN_SRL = 6'd5;
   localparam logic [5:0] FN_SLT = 6'd6;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
`ifdef CU_HALT_EN
      , S_HALT
`endif
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;

   logic [PC_WIDTH-1:0]    r_pc;
   logic [31:0]            r_ir;
   logic [XLEN-1:0]        r_a;
   logic [XLEN-1:0]        r_b;
   logic [XLEN-1:0]        r_res;
   logic [4:0]             r_dest;
   logic [XLEN-1:0]        r_regs [RF_DEPTH];
   logic                   r_imem_req;
   logic                   r_dmem_req;
   logic                   r_dmem_we;
   logic [DADDR_WIDTH-1:0] r_dmem_addr;
   logic [XLEN-1:0]        r_dmem_wdata;
   logic                   r_retire;

   // Instruction fields
   logic [5:0]             w_op;
   logic [4:0]             w_rs;
   logic [4:0]             w_rt;
   logic [4:0]             w_rd;
   logic [5:0]             w_funct;
   logic [15:0]            w_imm16;
   logic [XLEN-1:0]        w_sext;
   logic [XLEN-1:0]        w_zext;
   logic [PC_WIDTH-1:0]    w_jmp;
   logic [XLEN-1:0]        w_rs_val;
   logic [XLEN-1:0]        w_rt_val;
   logic [XLEN-1:0]        w_ea;
   logic [PC_WIDTH-1:0]    w_pc_inc;
   logic [PC_WIDTH-1:0]    w_pc_br;

   // Next-state / datapath controls
   logic [PC_WIDTH-1:0]    w_pc_next;
   logic                   w_retire;
   logic [XLEN-1:0]        w_alu;
   logic [4:0]             w_dest;
   logic                   w_mem_we;
   logic                   w_rf_we;
   logic [4:0]             w_rf_waddr;
   logic [XLEN-1:0]        w_rf_wdata;
   logic                   w_unused;

   assign w_op     = r_ir[31:26];
   assign w_rs     = r_ir[25:21];
   assign w_rt     = r_ir[20:16];
   assign w_rd     = r_ir[15:11];
   assign w_funct  = r_ir[5:0];
   assign w_imm16  = r_ir[15:0];
   assign w_sext   = XLEN'($signed(w_imm16));
   assign w_zext   = XLEN'(w_imm16);
   assign w_jmp    = r_ir[PC_WIDTH-1:0];
   assign w_ea     = r_a + w_sext;
   assign w_pc_inc = r_pc + PC_WIDTH'(1);
   assign w_pc_br  = w_pc_inc + w_sext[PC_WIDTH-1:0];

   // Indices beyond the implemented register count read as zero; r0 is never written
   assign w_rs_val = (32'(w_rs) < NREGS) ? r_regs[w_rs] : '0;
   assign w_rt_val = (32'(w_rt) < NREGS) ? r_regs[w_rt] : '0;

   // Instruction/operand bits not consumed by any decoded field
   assign w_unused = ^{r_ir, r_a, r_b, w_sext, w_ea};

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_FETCH;
      else      r_state <= w_next_state;
   end

   // Next-state, ALU and control decode
   always_comb begin
      w_next_state = r_state;
      w_pc_next    = r_pc;
      w_retire     = 1'b0;
      w_alu        = '0;
      w_dest       = '0;
      w_mem_we     = 1'b0;
      w_rf_we      = 1'b0;
      w_rf_waddr   = '0;
      w_rf_wdata   = '0;
      case (r_state)
         S_FETCH: begin
            if (r_imem_req && imem_ack) w_next_state = S_DECODE;
         end
         S_DECODE: w_next_state = S_EXEC;
         S_EXEC: begin
            case (w_op)
               OP_RTYPE: begin
                  w_dest       = w_rd;
                  w_next_state = S_WB;
                  case (w_funct)
                     FN_SUB:  w_alu = r_a - r_b;
                     FN_AND:  w_alu = r_a & r_b;
                     FN_OR:   w_alu = r_a | r_b;
                     FN_SLL:  w_alu = r_a << r_b[4:0];
                     FN_SRL:  w_alu = r_a >> r_b[4:0];
                     FN_SLT:  w_alu = XLEN'($signed(r_a) < $signed(r_b));
                     default: w_alu = r_a + r_b;
                  endcase
               end
               OP_ADDI: begin
                  w_alu = r_a + w_sext;  w_dest = w_rt;  w_next_state = S_WB;
               end
               OP_ANDI: begin
                  w_alu = r_a & w_zext;  w_dest = w_rt;  w_next_state = S_WB;
               end
               OP_ORI: begin
                  w_alu = r_a | w_zext;  w_dest = w_rt;  w_next_state = S_WB;
               end
               OP_SLTI: begin
                  w_alu = XLEN'($signed(r_a) < $signed(w_sext));
                  w_dest = w_rt;  w_next_state = S_WB;
               end
               OP_BEQ, OP_BNE: begin
                  w_pc_next    = ((r_a == r_b) == (w_op == OP_BEQ)) ? w_pc_br : w_pc_inc;
                  w_retire     = 1'b1;
                  w_next_state = S_FETCH;
               end
               OP_J: begin
                  w_pc_next = w_jmp;  w_retire = 1'b1;  w_next_state = S_FETCH;
               end
               OP_JR: begin
                  w_pc_next = r_a[PC_WIDTH-1:0];  w_retire = 1'b1;  w_next_state = S_FETCH;
               end
               OP_JAL: begin
                  w_rf_we      = 1'b1;
                  w_rf_waddr   = 5'd31;
                  w_rf_wdata   = XLEN'(w_pc_inc);
                  w_pc_next    = w_jmp;
                  w_retire     = 1'b1;
                  w_next_state = S_FETCH;
               end
               OP_LW: begin
                  w_dest = w_rt;  w_next_state = S_MEM;
               end
               OP_SW: begin
                  w_mem_we = 1'b1;  w_next_state = S_MEM;
               end
`ifdef CU_HALT_EN
               OP_HALT: begin
                  w_retire = 1'b1;  w_next_state = S_HALT;
               end
`endif
               default: begin
                  w_pc_next = w_pc_inc;  w_retire = 1'b1;  w_next_state = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (r_dmem_we) begin
                  w_pc_next = w_pc_inc;  w_retire = 1'b1;  w_next_state = S_FETCH;
               end else begin
                  w_next_state = S_WB;
               end
            end
         end
         S_WB: begin
            w_rf_we      = 1'b1;
            w_rf_waddr   = r_dest;
            w_rf_wdata   = r_res;
            w_pc_next    = w_pc_inc;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end
`ifdef CU_HALT_EN
         S_HALT: w_next_state = S_HALT;
`endif
         default: w_next_state = S_FETCH;
      endcase
   end

   // Datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc         <= '0;
         r_ir         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_res        <= '0;
         r_dest       <= '0;
         r_imem_req   <= 1'b0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_retire     <= 1'b0;
         for (int i = 0; i < RF_DEPTH; i++) r_regs[i] <= '0;
      end else begin
         r_pc       <= w_pc_next;
         r_retire   <= w_retire;
         r_imem_req <= (w_next_state == S_FETCH);
         r_dmem_req <= (w_next_state == S_MEM);
         if (r_state == S_FETCH && r_imem_req && imem_ack) r_ir <= imem_rdata;
         if (r_state == S_DECODE) begin
            r_a <= w_rs_val;
            r_b <= w_rt_val;
         end
         if (r_state == S_EXEC) begin
            r_res  <= w_alu;
            r_dest <= w_dest;
         end
         // Address/direction/data captured once on entry to MEM and held until ack
         if (r_state == S_EXEC && w_next_state == S_MEM) begin
            r_dmem_addr  <= w_ea[DADDR_WIDTH-1:0];
            r_dmem_we    <= w_mem_we;
            r_dmem_wdata <= r_b;
         end else if (w_next_state != S_MEM) begin
            r_dmem_we <= 1'b0;
         end
         if (r_state == S_MEM && dmem_ack && !r_dmem_we) r_res <= dmem_rdata;
         if (w_rf_we && w_rf_waddr != 5'd0 && 32'(w_rf_waddr) < NREGS)
            r_regs[w_rf_waddr] <= w_rf_wdata;
      end
   end

`ifdef CU_HALT_EN
   logic r_halted;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_halted <= 1'b0;
      else      r_halted <= (w_next_state == S_HALT);
   end
   assign halted = r_halted;
`else
   assign halted = 1'b0;
`endif

   assign imem_req   = r_imem_req;
   assign imem_addr  = r_pc;
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_wdata = r_dmem_wdata;
   assign pc         = r_pc;
   assign retire     = r_retire;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: wait-state memory models plus
// scoreboards of expected retirements (pc, latency) and expected stores.
module tb_multicycle_cu;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        dmem_req;
   logic        dmem_we;
   logic [9:0]  dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic [9:0]  pc;
   logic        retire;
   logic        halted;

   multicycle_cu dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .pc(pc), .retire(retire), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [9:0] pc; int lat; } ret_t;
   typedef struct { logic [9:0] addr; logic [31:0] data; } st_t;

   ret_t        exp_ret[$];
   st_t         exp_st[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // Memory models
   logic [31:0] imem [1024];
   logic [31:0] ld_data;
   int          iwait, dwait;
   int          icnt, dcnt;

   assign imem_rdata = imem[imem_addr];
   assign imem_ack   = imem_req && (icnt >= iwait);
   assign dmem_rdata = ld_data;
   assign dmem_ack   = dmem_req && (dcnt >= dwait);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         icnt <= 0;
         dcnt <= 0;
      end else begin
         icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
         dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
      end
   end

   // Data-access monitor: request length and address stability per access
   int          dlen;
   logic        daddr_bad;
   logic [9:0]  dprev;
   int          acc_len[$];
   logic [9:0]  acc_addr[$];
   always @(negedge clk) begin
      if (!rst) begin
         dlen = 0;
         daddr_bad = 1'b0;
         acc_len.delete();
         acc_addr.delete();
      end else if (dmem_req) begin
         dlen++;
         if (dlen > 1 && dmem_addr !== dprev) daddr_bad = 1'b1;
         dprev = dmem_addr;
         if (dmem_ack) begin
            acc_len.push_back(dlen);
            acc_addr.push_back(dmem_addr);
            dlen = 0;
         end
      end
   end

   function automatic logic [31:0] enc_r(int funct, int rd, int rs, int rt);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
   endfunction
   function automatic logic [31:0] enc_i(int op, int rt, int rs, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] enc_j(int op, int tgt);
      return {6'(op), 26'(tgt)};
   endfunction

   task automatic push_ret(input int p, input int lat);
      ret_t r;
      r.pc = 10'(p); r.lat = lat;
      exp_ret.push_back(r);
   endtask
   task automatic push_st(input int a, input logic [31:0] d);
      st_t s;
      s.addr = 10'(a); s.data = d;
      exp_st.push_back(s);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
   endtask

   task automatic do_reset(input int iw, input int dw);
      rst = 1'b0;
      iwait = iw;
      dwait = dw;
      exp_ret.delete();
      exp_st.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Advance until n_ret retirements, checking retire and store scoreboards
   task automatic run(input int n_ret, input int budget);
      int   got, cyc, lat;
      ret_t r;
      st_t  s;
      got = 0; cyc = 0; lat = 0;
      while (got < n_ret && cyc < budget) begin
         @(negedge clk);
         cyc++; lat++;
         if (dmem_req === 1'b1 && dmem_ack === 1'b1 && dmem_we === 1'b1) begin
            n_checks++;
            if (exp_st.size() == 0) begin
               $display("FAIL store_unexpected addr=%h data=%h required none", dmem_addr, dmem_wdata);
            end else begin
               s = exp_st.pop_front();
               if (dmem_addr !== s.addr || dmem_wdata !== s.data)
                  $display("FAIL store addr=%h data=%h required addr=%h data=%h",
                           dmem_addr, dmem_wdata, s.addr, s.data);
               else n_pass++;
            end
         end
         if (retire === 1'b1) begin
            got++;
            n_checks++;
            if (exp_ret.size() == 0) begin
               $display("FAIL retire_unexpected pc=%h required none", pc);
            end else begin
               r = exp_ret.pop_front();
               if (pc !== r.pc || (r.lat != 0 && lat != r.lat))
                  $display("FAIL retire pc=%h lat=%0d required pc=%h lat=%0d", pc, lat, r.pc, r.lat);
               else n_pass++;
            end
            lat = 0;
         end
      end
      n_checks++;
      if (got < n_ret || exp_st.size() != 0)
         $display("FAIL run_complete retired=%0d pending_stores=%0d required retired=%0d pending_stores=0",
                  got, exp_st.size(), n_ret);
      else n_pass++;
   endtask

   task automatic test_reset();
      clear_imem();
      rst = 1'b0;
      iwait = 0; dwait = 0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({imem_req, dmem_req, dmem_we, retire, halted} !== 5'b0 || pc !== 10'h0)
         $display("FAIL reset_outputs req/dreq/we/ret/halt=%b pc=%h required 00000 pc=000",
                  {imem_req, dmem_req, dmem_we, retire, halted}, pc);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (imem_req !== 1'b0) $display("FAIL reset_release_req imem_req=%b required 0", imem_req);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 10'h0)
         $display("FAIL first_fetch imem_req=%b addr=%h required 1 000", imem_req, imem_addr);
      else n_pass++;
   endtask

   task automatic test_alu();
      int          sreg [12] = '{3, 4, 5, 6, 7, 8, 10, 11, 12, 13, 0, 14};
      logic [31:0] sval [12] = '{32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd1, 32'd20,
                                 32'h3FFF_FFFF, 32'h0000_FF00, 32'h0000_8001, 32'd1, 32'd0, 32'd2};
      clear_imem();
      imem[0]  = enc_i(6'h0F, 1, 0, 5);
      imem[1]  = enc_i(6'h0F, 2, 0, -3);
      imem[2]  = enc_r(0, 3, 1, 2);
      imem[3]  = enc_r(1, 4, 1, 2);
      imem[4]  = enc_r(2, 5, 1, 2);
      imem[5]  = enc_r(3, 6, 1, 2);
      imem[6]  = enc_r(6, 7, 2, 1);
      imem[7]  = enc_i(6'h0F, 9, 0, 2);
      imem[8]  = enc_r(4, 8, 1, 9);
      imem[9]  = enc_r(5, 10, 2, 9);
      imem[10] = enc_i(6'h14, 11, 2, 16'hFF00);
      imem[11] = enc_i(6'h15, 12, 0, 16'h8001);
      imem[12] = enc_i(6'h0B, 13, 2, -2);
      imem[13] = enc_i(6'h0F, 0, 1, 7);
      imem[14] = enc_r(63, 14, 1, 2);
      do_reset(0, 0);
      for (int i = 0; i < 12; i++) begin
         imem[15 + i] = enc_i(6'h0D, sreg[i], 0, 16'h20 + i);
         push_st(16'h20 + i, sval[i]);
      end
      for (int i = 0; i < 27; i++) push_ret(i + 1, (i == 0) ? 0 : 4);
      run(27, 400);
   endtask

   task automatic test_lw_wait();
      clear_imem();
      ld_data = 32'h0000_DEAD;
      imem[0] = enc_i(6'h0F, 1, 0, 1);
      imem[1] = enc_i(6'h0C, 4, 0, 8);
      imem[2] = enc_i(6'h0D, 4, 0, 9);
      imem[3] = enc_i(6'h0D, 4, 1, 16'h0405);
      do_reset(0, 3);
      push_ret(1, 0); push_ret(2, 8); push_ret(3, 7); push_ret(4, 7);
      push_st(9, 32'h0000_DEAD);
      push_st(6, 32'h0000_DEAD);
      run(4, 200);
      n_checks++;
      if (acc_len.size() < 1) $display("FAIL lw_access none recorded required len=4 addr=008");
      else if (acc_len[0] != 4 || acc_addr[0] !== 10'h008)
         $display("FAIL lw_access len=%0d addr=%h required len=4 addr=008", acc_len[0], acc_addr[0]);
      else n_pass++;
      n_checks++;
      if (daddr_bad !== 1'b0) $display("FAIL dmem_addr_stable changed=%b required 0", daddr_bad);
      else n_pass++;
   endtask

   task automatic test_branch();
      clear_imem();
      imem[0] = enc_i(6'h0F, 1, 0, 1);
      imem[1] = enc_i(6'h02, 1, 1, 4);
      imem[2] = enc_i(6'h02, 0, 1, 2);
      imem[5] = enc_i(6'h01, 1, 1, -1);
      do_reset(0, 0);
      push_ret(1, 0); push_ret(2, 3); push_ret(5, 3);
      push_ret(5, 3); push_ret(5, 3); push_ret(5, 3);
      run(6, 200);
   endtask

   task automatic test_jump();
      clear_imem();
      imem[0]     = enc_j(6'h07, 7);
      imem[7]     = enc_j(6'h09, 16'h20);
      imem[10'h20] = enc_i(6'h08, 0, 31, 0);
      imem[8]     = enc_i(6'h0D, 31, 0, 16'h30);
      do_reset(1, 0);
      push_ret(7, 0); push_ret(16'h20, 4); push_ret(8, 4); push_ret(9, 5);
      push_st(16'h30, 32'd8);
      run(4, 200);
   endtask

   task automatic test_wrap();
      clear_imem();
      imem[0]      = enc_j(6'h07, 16'h13FF);
      imem[10'h3FF] = enc_i(6'h0F, 1, 0, 1);
      do_reset(0, 0);
      push_ret(16'h3FF, 0); push_ret(0, 4); push_ret(16'h3FF, 3); push_ret(0, 4);
      run(4, 200);
   endtask

   task automatic test_op3f();
      clear_imem();
      imem[0] = enc_i(6'h30, 0, 0, 0);
      imem[1] = enc_i(6'h3F, 0, 0, 0);
      do_reset(0, 0);
      push_ret(1, 0);
`ifdef CU_HALT_EN
      push_ret(1, 3);
      run(2, 100);
      repeat (5) @(negedge clk);
      n_checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0 || pc !== 10'h1)
         $display("FAIL halt halted=%b ireq=%b dreq=%b pc=%h required 1 0 0 001",
                  halted, imem_req, dmem_req, pc);
      else n_pass++;
`else
      push_ret(2, 3);
      run(2, 100);
      n_checks++;
      if (halted !== 1'b0) $display("FAIL op3f_nop halted=%b required 0", halted);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_mid();
      int n;
      clear_imem();
      imem[0] = enc_i(6'h0F, 1, 0, 1);
      imem[1] = enc_i(6'h0C, 2, 0, 4);
      do_reset(0, 50);
      n = 0;
      while (dmem_req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (dmem_req !== 1'b1 || pc !== 10'h1)
         $display("FAIL mid_setup dmem_req=%b pc=%h required 1 001", dmem_req, pc);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if (dmem_req !== 1'b0 || imem_req !== 1'b0 || pc !== 10'h0)
         $display("FAIL mid_reset dreq=%b ireq=%b pc=%h required 0 0 000", dmem_req, imem_req, pc);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 10'h0 || dmem_req !== 1'b0)
         $display("FAIL mid_restart ireq=%b addr=%h dreq=%b required 1 000 0",
                  imem_req, imem_addr, dmem_req);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b0;
      iwait = 0;
      dwait = 0;
      ld_data = 32'h0;
      test_reset();
      test_alu();
      test_lw_wait();
      test_branch();
      test_jump();
      test_wrap();
      test_op3f();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
